input_frame_loader: RTL and testbench
=====================================

// Module: input_frame_loader
// PURPOSE
//  Upstream feeder for the hidden-layer neurons. Takes a serial pixel stream on a
//  valid/ready handshake and deserialises NUM_PIXELS bytes into one frame. It appends
//  the bias byte and presents all NUM_PIXELS+1 bytes as one flat, stable vector.
//  Double-buffered: the next frame loads while the current frame waits for the layer.
// PARAMETERS
//  NUM_PIXELS  36     pixels per frame (6x6 image); output vector has NUM_PIXELS+1 bytes
//  DATA_W      8      bits per pixel/byte
//  BIAS_VALUE  8'd1   constant driven on the top byte (index NUM_PIXELS)
// PORTS
//  clk         in   1                      single clock, rising edge
//  rst_n       in   1                      asynchronous, active-low reset
//  pix_data    in   DATA_W                 pixel byte
//  pix_valid   in   1                      pix_data valid
//  pix_last    in   1                      marks final pixel of a frame
//  pix_ready   out  1                      loader accepts a beat (beat = valid&&ready)
//  frame_data  out  (NUM_PIXELS+1)*DATA_W  byte i at [i*DATA_W +: DATA_W]
//  frame_valid out  1                      frame_data holds a complete frame
//  frame_ready in   1                      consumer takes frame (xfer = valid&&ready)
//  frame_err   out  1                      one-cycle pulse on framing error
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, pix_ready=0, frame_valid=0,
//   frame_err=0, frame_data=0, pixel index=0, both banks empty.
//  States: IDLE -> FILL on first edge after release (unconditional).
//   FILL: pix_ready=1. Each beat writes byte[idx] of the fill bank; idx++.
//   FULL: fill bank complete, present bank occupied. pix_ready=0 until xfer.
//   RESYNC: pix_ready=1. Beats are dropped until a beat with pix_last; then -> FILL, idx=0.
//  Frame completion: beat at idx==NUM_PIXELS-1 with pix_last=1.
//   Present bank free, or freed by xfer in the same cycle: banks swap, idx=0, stay FILL.
//    frame_valid=1 from the next cycle. Latency is 1 cycle from last beat to frame_valid.
//   Otherwise -> FULL. On xfer in FULL: swap, frame_valid stays 1, -> FILL.
//    pix_ready is 1 in the cycle after the xfer.
//  xfer with no completed fill bank: frame_valid=0 next cycle.
//   Back-to-back frames have no bubble.
//  frame_data stays constant while frame_valid=1 and frame_ready=0.
//   It is never modified by incoming beats.
//  Top byte is always BIAS_VALUE. When frame_valid=0, frame_data keeps its last value.
//  Framing errors (partial frame discarded, frame_err pulses the cycle after the beat):
//   pix_last=1 at idx<NUM_PIXELS-1: idx=0, stay FILL.
//   pix_last=0 at idx==NUM_PIXELS-1: idx=0, -> RESYNC.
//  pix_valid=0 beats: no state change. Idle gaps of any length are legal.
//  rst_n low mid-frame: immediate clear per reset values. No partial frame survives.
//  idx is clog2(NUM_PIXELS) bits and never exceeds NUM_PIXELS-1.
// STRUCTURE
//  nn_pkg (shared): NUM_INPUTS=37, DATA_W=8, BIAS_VALUE, loader state enum
//   {IDLE,FILL,FULL,RESYNC}. The hidden layer uses the same NUM_INPUTS/DATA_W constants.
//  Sub-module pixel_bank: NUM_PIXELS x DATA_W register file.
//   Ports: indexed write (we, idx, data), flat read.
//   Instantiated twice; a bank-select bit picks the fill bank versus the present bank.
//  Top level holds the FSM, idx counter, bank-select bit, occupancy flags and error pulse.
// TESTING
//  1 Reset, send bytes 1..36 with pix_last on byte 36, frame_ready=1
//    -> frame_valid rises 1 cycle after beat 36; byte i==i+1; byte36==0x01; frame_err=0.
//  2 frame_ready=0, send frames A (0x10..) and B (0x50..)
//    -> pix_ready=0 after B's last beat; A stays stable.
//    Then frame_ready=1 -> A then B on consecutive cycles, no bubble.
//  3 pix_last on beat 10, then 36 clean beats
//    -> one frame_err pulse; exactly one frame_valid, carrying the clean 36 bytes.
//  4 Beat 36 without pix_last, then 5 junk beats (last with pix_last), then a clean frame
//    -> one frame_err pulse; junk dropped; clean frame delivered intact.
//  5 rst_n low at beat 20 for 3 cycles
//    -> frame_valid=0, pix_ready=0 immediately.
//    After release, a full frame delivers correct bytes with no stale data.
//  6 Random 50% pix_valid and frame_ready throttling over 100 frames
//    -> scoreboard matches every frame; byte36 always 0x01; no frame lost or duplicated.

Source files
------------

// File: rtl/nn_pkg.sv
// Constants and types shared by the input loader and the hidden layer.
package nn_pkg;

  localparam int unsigned NUM_INPUTS = 37;
  localparam int unsigned DATA_W     = 8;
  localparam logic [DATA_W-1:0] BIAS_VALUE = 8'd1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL,
    RESYNC
  } loader_state_t;

endpackage

// File: rtl/pixel_bank.sv
// One frame worth of pixel registers: indexed byte write, whole-frame flat read.
module pixel_bank #(
  parameter int unsigned NUM_PIXELS = 36,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned IDX_W      = $clog2(NUM_PIXELS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [IDX_W-1:0]             idx,
  input  logic [DATA_W-1:0]            data,
  output logic [NUM_PIXELS*DATA_W-1:0] rd_data
);

  logic [NUM_PIXELS-1:0][DATA_W-1:0] mem;

  // Comparator per entry keeps writes in range for any idx value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PIXELS; i++) begin
        if (we && (idx == IDX_W'(i))) begin
          mem[i] <= data;
        end
      end
    end
  end

  assign rd_data = mem;

endmodule

// File: rtl/input_frame_loader.sv
// Deserialises a pixel stream into double-buffered frames and presents each
// frame, with the bias byte on top, as one flat vector to the hidden layer.
module input_frame_loader import nn_pkg::*; #(
  parameter int unsigned NUM_PIXELS = nn_pkg::NUM_INPUTS - 1,
  parameter int unsigned DATA_W     = nn_pkg::DATA_W,
  parameter logic [DATA_W-1:0] BIAS_VALUE = nn_pkg::BIAS_VALUE
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_W-1:0]                pix_data,
  input  logic                             pix_valid,
  input  logic                             pix_last,
  output logic                             pix_ready,
  output logic [(NUM_PIXELS+1)*DATA_W-1:0] frame_data,
  output logic                             frame_valid,
  input  logic                             frame_ready,
  output logic                             frame_err
);

  localparam int unsigned IDX_W    = $clog2(NUM_PIXELS);
  localparam int unsigned PIX_BITS = NUM_PIXELS * DATA_W;

  loader_state_t        state;
  logic [IDX_W-1:0]     idx;
  logic                 bank_sel;   // index of the bank currently being filled
  logic                 beat;
  logic                 xfer;
  logic                 at_last;
  logic                 bank_we;
  logic [PIX_BITS-1:0]  bank0_rd;
  logic [PIX_BITS-1:0]  bank1_rd;

  assign beat    = pix_valid && pix_ready;
  assign xfer    = frame_valid && frame_ready;
  assign at_last = (idx == IDX_W'(NUM_PIXELS - 1));
  assign bank_we = beat && (state == FILL);

  pixel_bank #(
    .NUM_PIXELS (NUM_PIXELS),
    .DATA_W     (DATA_W),
    .IDX_W      (IDX_W)
  ) u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (bank_we && !bank_sel),
    .idx     (idx),
    .data    (pix_data),
    .rd_data (bank0_rd)
  );

  pixel_bank #(
    .NUM_PIXELS (NUM_PIXELS),
    .DATA_W     (DATA_W),
    .IDX_W      (IDX_W)
  ) u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (bank_we && bank_sel),
    .idx     (idx),
    .data    (pix_data),
    .rd_data (bank1_rd)
  );

  // The presented bank is never the write target, so frame_data holds while stalled.
  assign frame_data = {BIAS_VALUE, (bank_sel ? bank0_rd : bank1_rd)};

  // Loader FSM: frame_valid doubles as the present-bank occupancy flag, FULL as fill-bank full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      bank_sel    <= 1'b0;
      pix_ready   <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          state     <= FILL;
          pix_ready <= 1'b1;
        end

        FILL: begin
          if (xfer) begin
            frame_valid <= 1'b0;
          end
          if (beat) begin
            idx <= idx + IDX_W'(1);
            if (at_last && pix_last) begin
              idx <= '0;
              if (!frame_valid || frame_ready) begin
                bank_sel    <= ~bank_sel;
                frame_valid <= 1'b1;
              end else begin
                state     <= FULL;
                pix_ready <= 1'b0;
              end
            end else if (pix_last) begin
              idx       <= '0;
              frame_err <= 1'b1;
            end else if (at_last) begin
              idx       <= '0;
              frame_err <= 1'b1;
              state     <= RESYNC;
            end
          end
        end

        FULL: begin
          if (xfer) begin
            bank_sel  <= ~bank_sel;
            state     <= FILL;
            pix_ready <= 1'b1;
          end
        end

        RESYNC: begin
          if (xfer) begin
            frame_valid <= 1'b0;
          end
          if (beat && pix_last) begin
            state <= FILL;
            idx   <= '0;
          end
        end

        default: begin
          state     <= IDLE;
          pix_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_frame_loader.sv
// Directed and throttled-random checks of input_frame_loader against a frame scoreboard.
module tb_input_frame_loader;

  localparam int unsigned NP = 36;
  localparam int unsigned FW = (NP + 1) * 8;
  localparam int unsigned CW = 320;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    pix_data;
  logic          pix_valid;
  logic          pix_last;
  logic          pix_ready;
  logic [FW-1:0] frame_data;
  logic          frame_valid;
  logic          frame_ready;
  logic          frame_err;

  int n_chk = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int xfer_cnt = 0;
  logic [FW-1:0] exp_q[$];

  input_frame_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_last    (pix_last),
    .pix_ready   (pix_ready),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] seq_frame(input logic [7:0] base);
    logic [FW-1:0] f;
    f = '0;
    f[FW-1 -: 8] = 8'h01;
    for (int i = 0; i < NP; i++) f[i*8 +: 8] = base + 8'(i);
    return f;
  endfunction

  task automatic send_beat(input logic [7:0] d, input logic l, input bit thr);
    int n;
    n = 0;
    if (thr && ($urandom_range(0, 1) == 1)) begin
      pix_valid = 1'b0;
      @(posedge clk); #1;
    end
    pix_valid = 1'b1;
    pix_data  = d;
    pix_last  = l;
    while (!pix_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("pix_ready_wait", CW'(pix_ready), CW'(1));
    @(posedge clk); #1;
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input bit rnd, input bit push, input bit thr);
    logic [FW-1:0] f;
    f = seq_frame(base);
    if (rnd) begin
      for (int i = 0; i < NP; i++) f[i*8 +: 8] = 8'($urandom);
    end
    if (push) exp_q.push_back(f);
    for (int i = 0; i < NP; i++) send_beat(f[i*8 +: 8], (i == NP - 1), thr);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", CW'(exp_q.size()), CW'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int e0;
    int x0;
    bit done6;
    logic [FW-1:0] fa;
    logic [FW-1:0] fb;

    rst_n = 1'b0; pix_data = '0; pix_valid = 1'b0; pix_last = 1'b0; frame_ready = 1'b0;

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    fork
      begin
        logic          hold;
        logic [FW-1:0] held;
        logic [FW-1:0] expf;
        hold = 1'b0;
        held = '0;
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            hold = 1'b0;
          end else begin
            if (frame_err) err_cnt++;
            if (hold) check("hold_stable", {frame_valid, frame_data}, {1'b1, held});
            if (frame_valid && frame_ready) begin
              xfer_cnt++;
              check("bias_byte", CW'(frame_data[FW-1 -: 8]), CW'(8'h01));
              if (exp_q.size() == 0) begin
                check("unexpected_frame", CW'(frame_valid), CW'(0));
              end else begin
                expf = exp_q.pop_front();
                check("frame", frame_data, expf);
              end
            end
            hold = frame_valid && !frame_ready;
            held = frame_data;
          end
        end
      end
    join_none

    // 1: reset values, single frame 1..36, latency
    repeat (3) @(posedge clk);
    #1;
    check("rst_pix_ready", CW'(pix_ready), CW'(0));
    check("rst_frame_valid", CW'(frame_valid), CW'(0));
    check("rst_frame_err", CW'(frame_err), CW'(0));
    check("rst_frame_low", CW'(frame_data[FW-9:0]), CW'(0));
    check("rst_bias", CW'(frame_data[FW-1 -: 8]), CW'(8'h01));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("fill_ready", CW'(pix_ready), CW'(1));
    frame_ready = 1'b1;
    fa = seq_frame(8'd1);
    exp_q.push_back(fa);
    for (int i = 0; i < NP - 1; i++) send_beat(fa[i*8 +: 8], 1'b0, 1'b0);
    check("t1_valid_early", CW'(frame_valid), CW'(0));
    send_beat(fa[(NP-1)*8 +: 8], 1'b1, 1'b0);
    check("t1_valid", CW'(frame_valid), CW'(1));
    check("t1_data", frame_data, fa);
    check("t1_err", CW'(frame_err), CW'(0));
    @(posedge clk); #1;
    check("t1_valid_drop", CW'(frame_valid), CW'(0));
    drain();

    // 2: stall with two frames buffered, then back-to-back release
    frame_ready = 1'b0;
    fa = seq_frame(8'h10);
    fb = seq_frame(8'h50);
    send_frame(8'h10, 1'b0, 1'b1, 1'b0);
    send_frame(8'h50, 1'b0, 1'b1, 1'b0);
    check("t2_full_ready", CW'(pix_ready), CW'(0));
    check("t2_a_present", frame_data, fa);
    repeat (4) @(posedge clk);
    #1;
    check("t2_a_stable", frame_data, fa);
    check("t2_still_full", CW'(pix_ready), CW'(0));
    frame_ready = 1'b1;
    @(posedge clk); #1;
    check("t2_b_valid", CW'(frame_valid), CW'(1));
    check("t2_b_data", frame_data, fb);
    check("t2_ready_back", CW'(pix_ready), CW'(1));
    @(posedge clk); #1;
    check("t2_empty", CW'(frame_valid), CW'(0));
    drain();

    // 3: early pix_last, then a clean frame
    e0 = err_cnt; x0 = xfer_cnt;
    for (int i = 0; i < 10; i++) send_beat(8'hE0 + 8'(i), (i == 9), 1'b0);
    send_frame(8'h20, 1'b0, 1'b1, 1'b0);
    drain();
    check("t3_err", CW'(err_cnt - e0), CW'(1));
    check("t3_frames", CW'(xfer_cnt - x0), CW'(1));

    // 4: missing pix_last, junk until pix_last, then a clean frame
    e0 = err_cnt; x0 = xfer_cnt;
    for (int i = 0; i < NP; i++) send_beat(8'hA0 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_beat(8'hC0 + 8'(i), (i == 4), 1'b0);
    send_frame(8'h60, 1'b0, 1'b1, 1'b0);
    drain();
    check("t4_err", CW'(err_cnt - e0), CW'(1));
    check("t4_frames", CW'(xfer_cnt - x0), CW'(1));

    // 5: reset while a frame is presented and another is half loaded
    frame_ready = 1'b0;
    send_frame(8'h30, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) send_beat(8'h90 + 8'(i), 1'b0, 1'b0);
    check("t5_pre_valid", CW'(frame_valid), CW'(1));
    rst_n = 1'b0;
    #1;
    check("t5_valid_clr", CW'(frame_valid), CW'(0));
    check("t5_ready_clr", CW'(pix_ready), CW'(0));
    check("t5_data_clr", CW'(frame_data[FW-9:0]), CW'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    frame_ready = 1'b1;
    x0 = xfer_cnt;
    send_frame(8'h80, 1'b0, 1'b1, 1'b0);
    drain();
    check("t5_frames", CW'(xfer_cnt - x0), CW'(1));

    // 6: throttled traffic on both sides
    e0 = err_cnt; x0 = xfer_cnt;
    done6 = 1'b0;
    fork
      begin
        for (int f = 0; f < 100; f++) send_frame(8'h00, 1'b1, 1'b1, 1'b1);
        done6 = 1'b1;
      end
      begin
        while (!done6) begin
          frame_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        frame_ready = 1'b1;
      end
    join
    drain();
    check("t6_frames", CW'(xfer_cnt - x0), CW'(100));
    check("t6_err", CW'(err_cnt - e0), CW'(0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
